// File: rtl/div_seq_ctrl.sv
// Multi-cycle RV32M divide sequencer (DIV/DIVU/REM/REMU).
// Restoring shift-subtract datapath, one quotient bit per cycle, with
// divide-by-zero and signed overflow resolved on the accept edge.
module div_seq_ctrl #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_op,
  input  logic [XLEN-1:0] in_src1,
  input  logic [XLEN-1:0] in_src2,
  input  logic [4:0]      in_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_rd,
  output logic            busy
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StCalc = 2'd1;
  localparam logic [1:0] StFix  = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(XLEN - 1);

  logic [1:0]      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]      op_q, op_d;
  logic [4:0]      rd_q, rd_d;
  logic            qneg_q, qneg_d;
  logic            rneg_q, rneg_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN-1:0] res_q, res_d;
  logic [4:0]      out_rd_q, out_rd_d;

  // Accept-side decode: signedness, magnitudes and special cases.
  logic            is_signed;
  logic            s1_neg, s2_neg;
  logic [XLEN-1:0] mag1, mag2;
  logic            div_zero, sgn_ovf;
  logic            accept;

  // Iteration datapath.
  logic [XLEN:0]   rem_sh;
  logic [XLEN:0]   trial;
  logic [XLEN-1:0] quo_fix, rem_fix;

  // Decode the incoming request combinationally.
  always_comb begin
    is_signed = ~in_op[0];
    s1_neg    = is_signed & in_src1[XLEN-1];
    s2_neg    = is_signed & in_src2[XLEN-1];
    mag1      = s1_neg ? (~in_src1 + 1'b1) : in_src1;
    mag2      = s2_neg ? (~in_src2 + 1'b1) : in_src2;
    div_zero  = (in_src2 == '0);
    sgn_ovf   = is_signed & (in_src1 == MinNeg) & (in_src2 == '1);
    accept    = in_valid & (state_q == StIdle) & ~flush;
  end

  // One restoring step plus final sign correction.
  always_comb begin
    rem_sh  = {rem_q, quo_q[XLEN-1]};
    // Invariant rem < divisor keeps the true difference within 33 bits.
    trial   = rem_sh - {1'b0, dvs_q};
    quo_fix = qneg_q ? (~quo_q + 1'b1) : quo_q;
    rem_fix = rneg_q ? (~rem_q + 1'b1) : rem_q;
  end

  // Next-state and datapath register updates.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    rd_d     = rd_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    res_d    = res_q;
    out_rd_d = out_rd_q;

    if (flush) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            op_d   = in_op;
            rd_d   = in_rd;
            qneg_d = is_signed & (in_src1[XLEN-1] ^ in_src2[XLEN-1]);
            rneg_d = s1_neg;
            rem_d  = '0;
            quo_d  = mag1;
            dvs_d  = mag2;
            cnt_d  = '0;
            if (div_zero) begin
              res_d    = in_op[1] ? in_src1 : '1;
              out_rd_d = in_rd;
              state_d  = StDone;
            end else if (sgn_ovf) begin
              res_d    = in_op[1] ? '0 : MinNeg;
              out_rd_d = in_rd;
              state_d  = StDone;
            end else begin
              state_d = StCalc;
            end
          end
        end
        StCalc: begin
          if (!trial[XLEN]) begin
            rem_d = trial[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b1};
          end else begin
            rem_d = rem_sh[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b0};
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LastCnt) begin
            state_d = StFix;
          end
        end
        StFix: begin
          res_d    = op_q[1] ? rem_fix : quo_fix;
          out_rd_d = rd_q;
          state_d  = StDone;
        end
        StDone: begin
          if (out_ready) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      op_q     <= '0;
      rd_q     <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      res_q    <= '0;
      out_rd_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      res_q    <= res_d;
      out_rd_q <= out_rd_d;
    end
  end

  // Handshake and status outputs are pure state decodes.
  always_comb begin
    in_ready   = (state_q == StIdle);
    out_valid  = (state_q == StDone);
    busy       = (state_q != StIdle);
    out_result = res_q;
    out_rd     = out_rd_q;
  end

endmodule
